// File: rtl/cw305_obi_master_if.sv
// cw305_obi_master_if: host command/response and OBI bus signals of the CW305 OBI master
interface cw305_obi_master_if #(
    parameter int CntWidth = 16
);
    logic                cmd_valid_i;
    logic                cmd_ready_o;
    logic                cmd_we_i;
    logic [3:0]          cmd_be_i;
    logic [31:0]         cmd_addr_i;
    logic [31:0]         cmd_wdata_i;
    logic                resp_valid_o;
    logic                resp_err_o;
    logic [31:0]         resp_rdata_o;
    logic                busy_o;
    logic [CntWidth-1:0] txn_cnt_o;
    logic                req_o;
    logic                we_o;
    logic [3:0]          be_o;
    logic [31:0]         addr_o;
    logic [31:0]         wdata_o;
    logic                gnt_i;
    logic                rvalid_i;
    logic [31:0]         rdata_i;

    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_be_i, cmd_addr_i, cmd_wdata_i, gnt_i, rvalid_i, rdata_i,
        output cmd_ready_o, resp_valid_o, resp_err_o, resp_rdata_o, busy_o, txn_cnt_o,
               req_o, we_o, be_o, addr_o, wdata_o
    );

    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_be_i, cmd_addr_i, cmd_wdata_i, gnt_i, rvalid_i, rdata_i,
        input  cmd_ready_o, resp_valid_o, resp_err_o, resp_rdata_o, busy_o, txn_cnt_o,
               req_o, we_o, be_o, addr_o, wdata_o
    );
endinterface

// File: rtl/cw305_obi_master.sv
// cw305_obi_master: issues one OBI transaction per host command, with a grant-phase timeout
module cw305_obi_master #(
    parameter int TimeoutCycles = 1024,
    parameter int CntWidth = 16
) (
    input logic clk_i,
    input logic rst_i,
    cw305_obi_master_if.master bus
);
    localparam int TW = TimeoutCycles > 1 ? $clog2(TimeoutCycles) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TimeoutCycles > 0 ? TimeoutCycles - 1 : 0);

    typedef enum logic [2:0] {IDLE, REQ, WAIT, DONE, ERR} state_t;

    state_t state, state_n;
    logic [TW-1:0] tcnt;
    logic [CntWidth-1:0] cnt;
    logic accept;

    assign accept = state == IDLE && bus.cmd_valid_i;
    assign bus.txn_cnt_o = cnt;

    // grant wins over the timeout when both land on the same cycle
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = bus.cmd_valid_i ? REQ : IDLE;
            REQ:     state_n = bus.gnt_i ? WAIT : (TimeoutCycles != 0 && tcnt == TLAST) ? ERR : REQ;
            WAIT:    state_n = bus.rvalid_i ? DONE : WAIT;
            default: state_n = IDLE;
        endcase
    end

    // every output is registered from the next state so nothing is combinational to the bus
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state            <= IDLE;
            tcnt             <= '0;
            cnt              <= '0;
            bus.cmd_ready_o  <= 1'b1;
            bus.req_o        <= 1'b0;
            bus.we_o         <= 1'b0;
            bus.be_o         <= '0;
            bus.addr_o       <= '0;
            bus.wdata_o      <= '0;
            bus.resp_valid_o <= 1'b0;
            bus.resp_err_o   <= 1'b0;
            bus.resp_rdata_o <= '0;
            bus.busy_o       <= 1'b0;
        end else begin
            state            <= state_n;
            tcnt             <= state == REQ ? tcnt + 1'b1 : '0;
            bus.cmd_ready_o  <= state_n == IDLE;
            bus.req_o        <= state_n == REQ;
            bus.busy_o       <= state_n == REQ || state_n == WAIT;
            bus.resp_valid_o <= state_n == DONE || state_n == ERR;
            bus.resp_err_o   <= state_n == ERR;
            if (state_n == DONE || state_n == ERR) cnt <= cnt + 1'b1;
            if (accept) begin
                bus.we_o    <= bus.cmd_we_i;
                bus.be_o    <= bus.cmd_be_i;
                bus.addr_o  <= bus.cmd_addr_i & ~32'h3;
                bus.wdata_o <= bus.cmd_wdata_i;
            end
            if (state == WAIT && bus.rvalid_i && !bus.we_o) bus.resp_rdata_o <= bus.rdata_i;
        end
    end
endmodule

// File: tb/tb_cw305_obi_master.sv
// tb_cw305_obi_master: randomized self-checking bench against a transaction-level model
module tb_cw305_obi_master;
    localparam int TO = 8;
    localparam int CW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [31:0] m_rdata = '0;
    int m_cnt = 0;

    cw305_obi_master_if #(.CntWidth(CW)) bus();

    cw305_obi_master #(.TimeoutCycles(TO), .CntWidth(CW)) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // one full command; gd = REQ cycle index of the grant (>= TO means it never comes)
    task automatic run_txn(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata, input int gd, input int rd,
                           input logic [31:0] rdat, input bit keep, input bit stray,
                           output int acc_cyc);
        logic err;
        int n;
        logic [31:0] a;
        err = gd >= TO;
        n = err ? TO : gd + 1;
        a = {addr[31:2], 2'b00};
        total++;
        if (bus.cmd_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL idle_ready got=%b exp=1", bus.cmd_ready_o);
        end
        acc_cyc = cyc;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i = we;
        bus.cmd_be_i = be;
        bus.cmd_addr_i = addr;
        bus.cmd_wdata_i = wdata;
        tick();
        if (keep) begin
            bus.cmd_we_i = 1'($urandom);
            bus.cmd_be_i = 4'($urandom);
            bus.cmd_addr_i = $urandom;
            bus.cmd_wdata_i = $urandom;
        end else bus.cmd_valid_i = 1'b0;
        for (int k = 0; k < n; k++) begin
            bus.gnt_i = k == gd;
            bus.rvalid_i = stray ? 1'($urandom) : 1'b0;
            bus.rdata_i = $urandom;
            total++;
            if ({bus.req_o, bus.we_o, bus.be_o, bus.addr_o, bus.wdata_o, bus.busy_o, bus.cmd_ready_o, bus.resp_valid_o}
                !== {1'b1, we, be, a, wdata, 1'b1, 1'b0, 1'b0}) begin
                bad++;
                $display("FAIL req_phase k=%0d got req=%b we=%b be=%h addr=%h wdata=%h busy=%b rdy=%b rv=%b exp we=%b be=%h addr=%h wdata=%h",
                         k, bus.req_o, bus.we_o, bus.be_o, bus.addr_o, bus.wdata_o, bus.busy_o,
                         bus.cmd_ready_o, bus.resp_valid_o, we, be, a, wdata);
            end
            tick();
        end
        bus.gnt_i = 1'b0;
        bus.rvalid_i = 1'b0;
        if (!err) begin
            for (int k = 0; k < rd; k++) begin
                total++;
                if ({bus.req_o, bus.busy_o, bus.cmd_ready_o, bus.resp_valid_o} !== 4'b0100) begin
                    bad++;
                    $display("FAIL wait_phase k=%0d got req/busy/rdy/rv=%b%b%b%b exp=0100",
                             k, bus.req_o, bus.busy_o, bus.cmd_ready_o, bus.resp_valid_o);
                end
                tick();
            end
            bus.rvalid_i = 1'b1;
            bus.rdata_i = rdat;
            tick();
            bus.rvalid_i = 1'b0;
            bus.rdata_i = $urandom;
            if (!we) m_rdata = rdat;
        end
        m_cnt++;
        total++;
        if ({bus.resp_valid_o, bus.resp_err_o, bus.req_o, bus.busy_o, bus.cmd_ready_o} !== {1'b1, err, 3'b000}) begin
            bad++;
            $display("FAIL resp got rv=%b err=%b req=%b busy=%b rdy=%b exp rv=1 err=%b req=0 busy=0 rdy=0",
                     bus.resp_valid_o, bus.resp_err_o, bus.req_o, bus.busy_o, bus.cmd_ready_o, err);
        end
        total++;
        if (bus.resp_rdata_o !== m_rdata) begin
            bad++;
            $display("FAIL resp_rdata got=%h exp=%h", bus.resp_rdata_o, m_rdata);
        end
        total++;
        if (bus.txn_cnt_o !== CW'(m_cnt)) begin
            bad++;
            $display("FAIL txn_cnt got=%0d exp=%0d", bus.txn_cnt_o, CW'(m_cnt));
        end
        tick();
        total++;
        if ({bus.cmd_ready_o, bus.resp_valid_o, bus.resp_err_o} !== 3'b100) begin
            bad++;
            $display("FAIL after_resp got rdy/rv/err=%b%b%b exp=100", bus.cmd_ready_o, bus.resp_valid_o, bus.resp_err_o);
        end
    endtask

    task automatic test_reset();
        bus.cmd_valid_i = 1'b0;
        bus.cmd_we_i = 1'b0;
        bus.cmd_be_i = '0;
        bus.cmd_addr_i = '0;
        bus.cmd_wdata_i = '0;
        bus.gnt_i = 1'b0;
        bus.rvalid_i = 1'b0;
        bus.rdata_i = '0;
        rst = 1'b1;
        repeat (3) tick();
        total++;
        if ({bus.req_o, bus.we_o, bus.be_o, bus.addr_o, bus.wdata_o, bus.resp_valid_o, bus.resp_err_o,
             bus.resp_rdata_o, bus.busy_o, bus.txn_cnt_o} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got req=%b addr=%h wdata=%h rv=%b rdata=%h busy=%b cnt=%0d exp all 0",
                     bus.req_o, bus.addr_o, bus.wdata_o, bus.resp_valid_o, bus.resp_rdata_o, bus.busy_o, bus.txn_cnt_o);
        end
        rst = 1'b0;
        tick();
        total++;
        if ({bus.cmd_ready_o, bus.busy_o, bus.req_o} !== 3'b100) begin
            bad++;
            $display("FAIL reset_idle got rdy/busy/req=%b%b%b exp=100", bus.cmd_ready_o, bus.busy_o, bus.req_o);
        end
    endtask

    task automatic test_read_zero_wait();
        int c;
        run_txn(1'b0, 4'hF, 32'h2000_0007, 32'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 1'b0, c);
    endtask

    task automatic test_write_delayed();
        int c;
        run_txn(1'b1, 4'h3, 32'h10, 32'hA5A5_5A5A, 4, 0, 32'h1234_5678, 1'b0, 1'b0, c);
    endtask

    task automatic test_timeout();
        int c;
        run_txn(1'b0, 4'hF, 32'h4000_0000, 32'h0, 1000, 0, 32'h0, 1'b0, 1'b0, c);
        run_txn(1'b0, 4'h1, 32'h4000_0010, 32'h0, TO - 1, 1, 32'hCAFE_F00D, 1'b0, 1'b0, c);
    endtask

    task automatic test_back_to_back();
        int c[3];
        run_txn(1'b0, 4'hF, 32'h100, 32'h0, 0, 0, 32'h1111_1111, 1'b1, 1'b0, c[0]);
        run_txn(1'b1, 4'hC, 32'h104, 32'h5555_AAAA, 0, 0, 32'h2222_2222, 1'b1, 1'b0, c[1]);
        run_txn(1'b0, 4'h6, 32'h108, 32'h0, 0, 0, 32'h3333_3333, 1'b0, 1'b0, c[2]);
        for (int i = 1; i < 3; i++) begin
            total++;
            if (c[i] - c[i-1] != 4) begin
                bad++;
                $display("FAIL b2b_period i=%0d got=%0d exp=4", i, c[i] - c[i-1]);
            end
        end
    endtask

    task automatic test_stray_rvalid();
        for (int k = 0; k < 3; k++) begin
            bus.rvalid_i = 1'b1;
            bus.rdata_i = $urandom;
            tick();
            total++;
            if ({bus.resp_valid_o, bus.cmd_ready_o, bus.resp_rdata_o, bus.txn_cnt_o} !== {2'b01, m_rdata, CW'(m_cnt)}) begin
                bad++;
                $display("FAIL stray_rvalid got rv=%b rdy=%b rdata=%h cnt=%0d exp rv=0 rdy=1 rdata=%h cnt=%0d",
                         bus.resp_valid_o, bus.cmd_ready_o, bus.resp_rdata_o, bus.txn_cnt_o, m_rdata, CW'(m_cnt));
            end
        end
        bus.rvalid_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        int c;
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i = 1'b0;
        bus.cmd_be_i = 4'hF;
        bus.cmd_addr_i = 32'h3000_0000;
        tick();
        bus.cmd_valid_i = 1'b0;
        bus.gnt_i = 1'b1;
        tick();
        bus.gnt_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({bus.req_o, bus.we_o, bus.be_o, bus.addr_o, bus.wdata_o, bus.resp_valid_o, bus.resp_err_o,
             bus.resp_rdata_o, bus.busy_o, bus.txn_cnt_o} !== '0) begin
            bad++;
            $display("FAIL async_reset got req=%b be=%h addr=%h rdata=%h busy=%b cnt=%0d exp all 0",
                     bus.req_o, bus.be_o, bus.addr_o, bus.resp_rdata_o, bus.busy_o, bus.txn_cnt_o);
        end
        m_rdata = '0;
        m_cnt = 0;
        tick();
        rst = 1'b0;
        bus.rvalid_i = 1'b1;
        bus.rdata_i = 32'hBAD0_BAD0;
        tick();
        bus.rvalid_i = 1'b0;
        total++;
        if ({bus.resp_valid_o, bus.cmd_ready_o, bus.resp_rdata_o, bus.txn_cnt_o} !== {2'b01, 32'h0, CW'(0)}) begin
            bad++;
            $display("FAIL late_rvalid got rv=%b rdy=%b rdata=%h cnt=%0d exp rv=0 rdy=1 rdata=0 cnt=0",
                     bus.resp_valid_o, bus.cmd_ready_o, bus.resp_rdata_o, bus.txn_cnt_o);
        end
        run_txn(1'b0, 4'hF, 32'h3000_0004, 32'h0, 1, 2, 32'h0BAD_F00D, 1'b0, 1'b0, c);
    endtask

    task automatic test_random();
        int c;
        for (int i = 0; i < 24; i++)
            run_txn(1'($urandom), 4'($urandom), $urandom, $urandom, int'($urandom_range(0, 10)),
                    int'($urandom_range(0, 3)), $urandom, 1'($urandom), 1'b1, c);
        bus.cmd_valid_i = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_zero_wait();
        test_write_delayed();
        test_timeout();
        test_back_to_back();
        test_stray_rvalid();
        test_reset_mid();
        test_random();
        test_stray_rvalid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/cw305_obi_master.md
# cw305_obi_master

Host-command-to-OBI master that drives the X-HEEP external bridge port (req/we/be/addr/wdata in, gnt/rvalid/rdata out) from the CW305 USB register interface. It sits directly upstream of the MCU bridge port. It accepts one host command at a time through a valid/ready handshake and issues exactly one OBI transaction per command. When the transaction completes, it returns a one-cycle response carrying read data or an error flag. A grant-phase timeout lets the host recover from accesses to unmapped or hung addresses.

## Interface
Parameters:
- TimeoutCycles, default 1024: maximum cycles req_o may wait for gnt_i. A value of 0 disables the timeout.
- CntWidth, default 16: width of the completed-transaction counter.

Ports:
- clk_i  in  1  system clock; all logic is on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- cmd_valid_i  in  1  host command valid.
- cmd_ready_o  out  1  block idle and able to accept a command.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_be_i  in  4  byte enables.
- cmd_addr_i  in  32  byte address; bits [1:0] are ignored.
- cmd_wdata_i  in  32  write data.
- resp_valid_o  out  1  one-cycle completion pulse.
- resp_err_o  out  1  qualifies resp_valid_o; 1 = grant timeout.
- resp_rdata_o  out  32  last successful read data; held between reads.
- busy_o  out  1  a transaction is in flight.
- txn_cnt_o  out  CntWidth  count of completed transactions (ok or error); wraps.
- req_o  out  1  OBI request.
- we_o  out  1  OBI write enable.
- be_o  out  4  OBI byte enables.
- addr_o  out  32  OBI address; always {cmd_addr[31:2], 2'b00}.
- wdata_o  out  32  OBI write data.
- gnt_i  in  1  OBI grant.
- rvalid_i  in  1  OBI response valid.
- rdata_i  in  32  OBI read data.

## Operation
FSM states:
- IDLE: cmd_ready_o=1. cmd_valid_i&cmd_ready_o latches we/be/addr/wdata into output registers, clears the timeout counter, goes to REQ.
- REQ: req_o=1; we/be/addr/wdata stable. gnt_i=1 -> WAIT. If TimeoutCycles≠0 and the counter reaches TimeoutCycles-1 with gnt_i=0 -> ERR. gnt_i takes priority over the timeout in the same cycle. rvalid_i is ignored in this state.
- WAIT: req_o=0. The block waits for rvalid_i indefinitely; it has no timeout after grant. rvalid_i=1 -> DONE. On a read, rdata_i is captured into resp_rdata_o.
- DONE: resp_valid_o=1, resp_err_o=0, txn_cnt_o+1, then -> IDLE.
- ERR: resp_valid_o=1, resp_err_o=1, txn_cnt_o+1, then -> IDLE. resp_rdata_o is unchanged.

Rules:
- Exactly one outstanding transaction; there is no pipelining.
- cmd_ready_o is 0 in every state except IDLE.
- busy_o=1 in REQ and WAIT.
- Write responses do not modify resp_rdata_o.
- txn_cnt_o wraps from 2^CntWidth-1 to 0.
- rvalid_i seen in IDLE, REQ, DONE or ERR is a protocol error. It is ignored, with no state change and no capture.
- A timeout in REQ drops req_o without a grant. This is an intentional recovery abort; the bridge must tolerate it.

Reset (rst_i=1, asynchronous, at any time including mid-transaction):
- State goes to IDLE.
- req_o=0, we_o=0, be_o=0, addr_o=0, wdata_o=0.
- resp_valid_o=0, resp_err_o=0, resp_rdata_o=0, busy_o=0, txn_cnt_o=0, timeout counter=0.
- A mid-transaction response arriving after reset release is ignored.

## Timing
- Cycle 0: command handshake in IDLE.
- Cycle 1: req_o=1, with all OBI outputs registered.
- A grant on cycle g moves the FSM to WAIT on g+1.
- rvalid_i on cycle r moves the FSM to DONE on r+1, where resp_valid_o=1 and resp_rdata_o is valid.
- Minimum command-to-response latency: 3 cycles (gnt at cycle 1, rvalid at cycle 2, resp at cycle 3).
- The next command can be accepted on the cycle after resp_valid_o, so the minimum command period is 4 cycles.
- Timeout: req_o stays high for exactly TimeoutCycles cycles; resp_valid_o/resp_err_o follow on the next cycle.
- All outputs are registered; there is no combinational path from OBI inputs to OBI outputs.

## Test plan
- Read, zero wait: cmd read addr=0x2000_0007, be=0xF; gnt at cycle 1, rvalid with rdata=0xDEADBEEF at cycle 2 -> addr_o=0x2000_0004; resp_valid_o at cycle 3, err=0, resp_rdata_o=0xDEADBEEF; txn_cnt_o=1.
- Write with delayed grant: cmd write addr=0x10, wdata=0xA5A5_5A5A, be=0x3; gnt after 5 cycles -> req/we/be/addr/wdata stable for all 5 cycles; resp err=0; resp_rdata_o unchanged from the previous read.
- Timeout: TimeoutCycles=8, gnt never asserted -> req_o high exactly 8 cycles; resp_valid_o=1 and resp_err_o=1 on the 9th; cmd_ready_o=1 the cycle after. Also gnt on the final timeout cycle -> no error; the transaction completes normally.
- Back-to-back: cmd_valid_i held high with 3 commands and zero-wait slave -> one command accepted every 4 cycles; cmd_ready_o low while busy; txn_cnt_o=3.
- Stray rvalid and wrap: rvalid_i pulsed in IDLE -> no resp_valid_o, no capture. CntWidth=2 with 5 transactions -> txn_cnt_o=1.
- Reset mid-transaction: rst_i asserted in WAIT -> all outputs 0 immediately (asynchronous); a late rvalid_i after release is ignored; the next command works normally.
